fft_sequencer: RTL and testbench

Address and control sequencer for the in-place radix-2 decimation-in-time FFT. It walks all stages and butterflies and drives the sample-RAM read addresses and the twiddle ROM address (N/2-entry ROM, LOG2N-1 address bits). It hands each butterfly to the butterfly engine over a valid/ready handshake. Between stages it stalls for a fixed pipeline-drain interval, which prevents read-after-write hazards in the shared sample RAM.

---
 rtl/fft_sequencer.sv | 114 +++++++++++
 tb/tb_fft_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fft_sequencer.sv
// Address/control sequencer for an in-place radix-2 DIT FFT: walks stages and
// butterflies, issues sample and twiddle addresses over valid/ready, drains between stages.
module fft_sequencer #(
  parameter int unsigned LOG2N      = 10,
  parameter int unsigned PIPE_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bf_ready,
  output logic             bf_valid,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic [3:0]       stage,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BW         = LOG2N - 1;
  localparam logic [3:0]  LAST_STAGE = 4'(LOG2N - 1);
  localparam logic [3:0]  DRAIN_INIT = 4'(PIPE_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [3:0]    stage_q, stage_d;
  logic [BW-1:0] b_q, b_d;
  logic [3:0]    cnt_q, cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every next-state signal gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          stage_d = '0;
          b_d     = '0;
        end
      end
      S_RUN: begin
        if (bf_ready) begin
          if (b_q == '1) begin
            state_d = S_DRAIN;
            cnt_d   = DRAIN_INIT;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (stage_q == LAST_STAGE) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            stage_d = stage_q + 4'd1;
            b_d     = '0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stage_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Butterfly b of a stage: a zero bit is inserted into b at bit position 'stage'.
  logic [LOG2N-1:0] b_ext, span, pos, addr_a_raw;
  logic [BW-1:0]    tw_full;
  logic [3:0]       tw_sh;
  logic             run;

  always_comb begin
    b_ext      = {1'b0, b_q};
    span       = {{(LOG2N-1){1'b0}}, 1'b1} << stage_q;
    pos        = b_ext & (span - 1'b1);
    addr_a_raw = ((b_ext >> stage_q) << ({1'b0, stage_q} + 5'd1)) | pos;
    tw_sh      = LAST_STAGE - stage_q;
    tw_full    = pos[BW-1:0] << tw_sh;
    run        = (state_q == S_RUN);
  end

  assign bf_valid = run;
  assign addr_a   = run ? addr_a_raw        : '0;
  assign addr_b   = run ? addr_a_raw + span : '0;
  assign tw_addr  = run ? tw_full           : '0;
  assign stage    = stage_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_fft_sequencer.sv
// Bench for fft_sequencer: small-config directed scenarios plus a default-config
// run with random bf_ready, all checked against a loop-based reference of the FFT schedule.
module tb_fft_sequencer;

  localparam int SL = 3;
  localparam int SP = 2;
  localparam int GL = 10;
  localparam int GP = 4;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] tw;
    logic [3:0]  st;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          s_reset, s_start, s_ready, s_valid, s_busy, s_done;
  logic [SL-1:0] s_a, s_b;
  logic [SL-2:0] s_tw;
  logic [3:0]    s_stage;

  logic          g_reset, g_start, g_ready, g_valid, g_busy, g_done;
  logic [GL-1:0] g_a, g_b;
  logic [GL-2:0] g_tw;
  logic [3:0]    g_stage;

  fft_sequencer #(.LOG2N(SL), .PIPE_DEPTH(SP)) u_small (
    .clk(clk), .reset(s_reset), .start(s_start), .bf_ready(s_ready),
    .bf_valid(s_valid), .addr_a(s_a), .addr_b(s_b), .tw_addr(s_tw),
    .stage(s_stage), .busy(s_busy), .done(s_done)
  );

  fft_sequencer #(.LOG2N(GL), .PIPE_DEPTH(GP)) u_big (
    .clk(clk), .reset(g_reset), .start(g_start), .bf_ready(g_ready),
    .bf_valid(g_valid), .addr_a(g_a), .addr_b(g_b), .tw_addr(g_tw),
    .stage(g_stage), .busy(g_busy), .done(g_done)
  );

  int   checks = 0;
  int   errors = 0;
  rec_t ref_s[$];
  rec_t ref_g[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Schedule from the FFT definition: per stage, groups of 2^(s+1) samples, pairs span 2^s apart.
  task automatic build_ref(input int l2n, input bit big);
    rec_t e;
    for (int s = 0; s < l2n; s++)
      for (int g = 0; g < (1 << (l2n - 1 - s)); g++)
        for (int p = 0; p < (1 << s); p++) begin
          e.a  = 16'(g * (2 << s) + p);
          e.b  = 16'(g * (2 << s) + p + (1 << s));
          e.tw = 16'(p * (1 << (l2n - 1 - s)));
          e.st = 4'(s);
          if (big) ref_g.push_back(e);
          else     ref_s.push_back(e);
        end
  endtask

  task automatic run_small(input string name, input int stall_n, input bit spurious,
                           input int rst_at, input int exp_done);
    rec_t iss[$];
    int   got_done   = -1;
    int   done_cnt   = 0;
    int   stall_left = stall_n;
    int   per        = (1 << (SL - 1)) + SP;
    int   total      = SL * per;
    bit   rv, expv;
    rec_t r;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        if (s_done) begin
          done_cnt++;
          if (got_done < 0) got_done = k;
        end
        if (got_done >= 0 && k == got_done + 1)
          check($sformatf("%s_busy_fall c%0d", name, k), 64'(s_busy), 64'd0);
        if (stall_n == 0 && rst_at < 0) begin
          expv = (k <= total) && (((k - 1) % per) < (1 << (SL - 1)));
          check($sformatf("%s_valid c%0d", name, k), 64'(s_valid), 64'(expv));
          check($sformatf("%s_done c%0d", name, k), 64'(s_done), 64'(k == total + 1));
          check($sformatf("%s_busy c%0d", name, k), 64'(s_busy), 64'(k <= total + 1));
          if (!s_valid)
            check($sformatf("%s_idle_addr c%0d", name, k), 64'({s_a, s_b, s_tw}), 64'd0);
        end
      end
      s_start = (k == 0) || (spurious && (k == 3 || k == 8 || k == 19));
      rv = 1'b1;
      if (stall_left > 0 && s_valid && s_stage == 4'd1 && s_a == 3'd1) begin
        rv = 1'b0;
        stall_left--;
        check($sformatf("%s_stall_hold c%0d", name, k), 64'({s_a, s_b, s_tw}),
              64'({3'd1, 3'd3, 2'd2}));
      end
      s_ready = rv;
      if (k == rst_at) begin
        s_reset = 1'b1;
        #1;
        check($sformatf("%s_async_zero", name),
              64'({s_valid, s_a, s_b, s_tw, s_stage, s_busy, s_done}), 64'd0);
        @(negedge clk);
        s_reset = 1'b0;
        s_start = 1'b0;
        return;
      end
      if (s_valid && s_ready) begin
        r.a = 16'(s_a); r.b = 16'(s_b); r.tw = 16'(s_tw); r.st = s_stage;
        iss.push_back(r);
      end
    end
    s_start = 1'b0;
    check($sformatf("%s_count", name), 64'(iss.size()), 64'(ref_s.size()));
    for (int i = 0; i < ref_s.size(); i++)
      if (i < iss.size())
        check($sformatf("%s_bf%0d", name, i), 64'(iss[i]), 64'(ref_s[i]));
    check($sformatf("%s_done_cycle", name), 64'(got_done), 64'(exp_done));
    check($sformatf("%s_done_pulses", name), 64'(done_cnt), 64'd1);
  endtask

  initial begin
    int  nhs = 0, bad = 0, seen_done = 0, k;
    int  use_cnt[1024];
    rec_t r;

    s_reset = 1'b1; s_start = 1'b0; s_ready = 1'b0;
    g_reset = 1'b1; g_start = 1'b0; g_ready = 1'b0;
    build_ref(SL, 1'b0);
    build_ref(GL, 1'b1);
    repeat (3) @(negedge clk);
    check("reset_small", 64'({s_valid, s_a, s_b, s_tw, s_stage, s_busy, s_done}), 64'd0);
    check("reset_big",   64'({g_valid, g_a, g_b, g_tw, g_stage, g_busy, g_done}), 64'd0);
    s_reset = 1'b0;
    g_reset = 1'b0;
    @(negedge clk);

    run_small("nominal",  0, 1'b0, -1, 19);
    run_small("backpres", 3, 1'b0, -1, 22);
    run_small("ignstart", 0, 1'b1, -1, 19);
    run_small("midreset", 0, 1'b0,  9,  0);
    run_small("afterrst", 0, 1'b0, -1, 19);

    foreach (use_cnt[i]) use_cnt[i] = 0;
    for (k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (g_done) begin
        seen_done = 1;
        break;
      end
      g_start = (k == 0);
      g_ready = ($urandom_range(0, 3) != 0);
      if (g_valid && g_ready) begin
        check($sformatf("big_span h%0d", nhs), 64'(g_b - g_a), 64'(1 << g_stage));
        r.a = 16'(g_a); r.b = 16'(g_b); r.tw = 16'(g_tw); r.st = g_stage;
        if (nhs < ref_g.size())
          check($sformatf("big_bf h%0d", nhs), 64'(r), 64'(ref_g[nhs]));
        use_cnt[g_a]++;
        use_cnt[g_b]++;
        nhs++;
        if (nhs % 512 == 0) begin
          bad = 0;
          foreach (use_cnt[i]) begin
            if (use_cnt[i] != 1) bad++;
            use_cnt[i] = 0;
          end
          check($sformatf("big_use stage%0d", nhs / 512 - 1), 64'(bad), 64'd0);
        end
      end
    end
    g_start = 1'b0;
    check("big_done_seen", 64'(seen_done), 64'd1);
    check("big_handshakes", 64'(nhs), 64'(GL * 512));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
